// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-look-ahead adder/subtractor: one GROUP-bit look-ahead group
// per stage, group carry registered between stages, valid/ready on both sides.

module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout
);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             gen_any;
    logic             prop_all;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products over g/p/cin, so no carry waits on another.
    always_comb begin
        c        = '0;
        gen_any  = 1'b0;
        prop_all = 1'b1;
        c[0]     = cin;
        for (int i = 0; i < GROUP; i++) begin
            gen_any  = 1'b0;
            prop_all = 1'b1;
            for (int j = i; j >= 0; j--) begin
                gen_any  = gen_any | (prop_all & g[j]);
                prop_all = prop_all & p[j];
            end
            c[i+1] = gen_any | (prop_all & cin);
        end
    end

    assign s    = p ^ c[GROUP-1:0];
    assign cout = c[GROUP];
endmodule

module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int GSAFE = (GROUP < 1) ? 1 : GROUP;
    localparam int NSTG  = WIDTH / GSAFE;

    if ((GROUP < 1) || ((WIDTH % GSAFE) != 0)) begin : g_param_check
        $fatal(1, "cla_pipe_addsub: WIDTH must be a positive multiple of GROUP");
    end

    // vld_pipe[k] is stage k; vld_pipe[NSTG] is the output register.
    logic [NSTG:0]    vld_pipe;
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign adv       = ~vld_pipe[NSTG] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[NSTG];
    assign b_eff     = in_sub ? ~in_b : in_b;
    assign c0        = in_sub | in_cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[NSTG-1:0], in_valid};
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        // Operand bits still ahead of this stage, kept right-aligned.
        localparam int REM = WIDTH - (k + 1) * GROUP;

        logic [GROUP-1:0]       a_grp;
        logic [GROUP-1:0]       b_grp;
        logic [GROUP-1:0]       s_grp;
        logic                   c_in;
        logic                   c_out;
        logic [(k+1)*GROUP-1:0] sum_nxt;
        logic [(k+1)*GROUP-1:0] sum_q;
        logic                   a_msb_nxt;
        logic                   b_msb_nxt;
        logic                   c_q;
        logic                   a_msb_q;
        logic                   b_msb_q;

        if (k == 0) begin : g_src
            assign a_grp     = in_a[GROUP-1:0];
            assign b_grp     = b_eff[GROUP-1:0];
            assign c_in      = c0;
            assign sum_nxt   = s_grp;
            assign a_msb_nxt = in_a[WIDTH-1];
            assign b_msb_nxt = b_eff[WIDTH-1];
        end else begin : g_src
            assign a_grp     = g_stg[k-1].g_rem.a_rem_q[GROUP-1:0];
            assign b_grp     = g_stg[k-1].g_rem.b_rem_q[GROUP-1:0];
            assign c_in      = g_stg[k-1].c_q;
            assign sum_nxt   = {s_grp, g_stg[k-1].sum_q};
            assign a_msb_nxt = g_stg[k-1].a_msb_q;
            assign b_msb_nxt = g_stg[k-1].b_msb_q;
        end

        cla_group #(.GROUP(GROUP)) u_grp (
            .a    (a_grp),
            .b    (b_grp),
            .cin  (c_in),
            .s    (s_grp),
            .cout (c_out)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                c_q     <= 1'b0;
                a_msb_q <= 1'b0;
                b_msb_q <= 1'b0;
            end else if (adv) begin
                sum_q   <= sum_nxt;
                c_q     <= c_out;
                a_msb_q <= a_msb_nxt;
                b_msb_q <= b_msb_nxt;
            end
        end

        if (k < NSTG - 1) begin : g_rem
            logic [REM-1:0] a_rem_nxt;
            logic [REM-1:0] b_rem_nxt;
            logic [REM-1:0] a_rem_q;
            logic [REM-1:0] b_rem_q;

            if (k == 0) begin : g_nxt
                assign a_rem_nxt = in_a[WIDTH-1:GROUP];
                assign b_rem_nxt = b_eff[WIDTH-1:GROUP];
            end else begin : g_nxt
                assign a_rem_nxt = g_stg[k-1].g_rem.a_rem_q[REM+GROUP-1:GROUP];
                assign b_rem_nxt = g_stg[k-1].g_rem.b_rem_q[REM+GROUP-1:GROUP];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else if (adv) begin
                    a_rem_q <= a_rem_nxt;
                    b_rem_q <= b_rem_nxt;
                end
            end
        end
    end

    logic last_a_msb;
    logic last_b_msb;
    logic last_s_msb;

    assign last_a_msb = g_stg[NSTG-1].a_msb_q;
    assign last_b_msb = g_stg[NSTG-1].b_msb_q;
    assign last_s_msb = g_stg[NSTG-1].sum_q[WIDTH-1];

    // Result data only loads with a real beat, so it stays 0 until the first one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (adv && vld_pipe[NSTG-1]) begin
            out_sum  <= g_stg[NSTG-1].sum_q;
            out_cout <= g_stg[NSTG-1].c_q;
            out_ovf  <= (last_a_msb == last_b_msb) & (last_s_msb != last_a_msb);
        end
    end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub: accepted beats push an arithmetic
// reference result; a monitor pops and compares each delivered result.

module tb_cla_pipe_addsub;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } dvec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic fix_en;
    exp_t fix_exp;
    bit   hold;

    cla_pipe_addsub #(.WIDTH(W), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t r;
        int   u;
        int   s;
        if (sub) begin
            u      = int'(a) - int'(b);
            s      = int'($signed(a)) - int'($signed(b));
            r.cout = (u >= 0);
        end else begin
            u      = int'(a) + int'(b) + int'(cin);
            s      = int'($signed(a)) + int'($signed(b)) + int'(cin);
            r.cout = (u > 65535);
        end
        r.sum = u[W-1:0];
        r.ovf = (s > 32767) || (s < -32768);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd16();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Issue side: every accepted beat pushes its expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            if (fix_en) sb.push_back(fix_exp);
            else        sb.push_back(model(in_a, in_b, in_cin, in_sub));
        end
    end

    // Monitor side: every delivered result pops and compares.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result got sum=%h cout=%b ovf=%b exp none",
                         out_sum, out_cout, out_ovf);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf) begin
                    miscompares++;
                    $display("FAIL result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                             out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Presents one beat and returns just after the edge that accepts it.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout got=0 exp=1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic latency(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub);
        send(a, b, cin, sub);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk(name, 32'(out_valid), 32'(k == 4));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dvec_t dir[7];
        logic [16:0] pat;
        logic [W-1:0] held_sum;
        logic held_cout;
        logic held_ovf;

        dir = '{
            '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
            '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
            '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0},
            '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
            '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0},
            '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1},
            '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0}
        };

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        fix_en    = 1'b0;
        fix_exp   = '0;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(out_sum), 32'd0);
        chk("reset_cout", 32'(out_cout), 32'd0);
        chk("reset_ovf", 32'(out_ovf), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_sum", 32'(out_sum), 32'd0);

        // First beat after reset: fixed expectation and latency
        fix_en  = 1'b1;
        fix_exp = '{16'h5555, 1'b0, 1'b0};
        latency("latency_first", 16'h1234, 16'h4321, 1'b0, 1'b0);

        // Directed carry / borrow / overflow corners, back to back
        for (int i = 0; i < 7; i++) begin
            fix_exp = '{dir[i].sum, dir[i].cout, dir[i].ovf};
            send(dir[i].a, dir[i].b, dir[i].cin, dir[i].sub);
        end
        idle(8);
        fix_en = 1'b0;
        chk("directed_drained", 32'(sb.size()), 32'd0);

        // Backpressure mid-stream: 8 beats A=i, B=3i
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'(i), 16'(3 * i), 1'b0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held_sum  = out_sum;
                held_cout = out_cout;
                held_ovf  = out_ovf;
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_valid", 32'(out_valid), 32'd1);
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_sum_stable", 32'(out_sum), 32'(held_sum));
                    chk("stall_flags_stable", 32'({out_cout, out_ovf}), 32'({held_cout, held_ovf}));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(10);
        chk("stream_drained", 32'(sb.size()), 32'd0);

        // Bubbles: out_valid must replay the in_valid pattern five loop steps later
        pat = 17'b0_0000_1101_0101_0101;
        for (int m = 0; m < 17; m++) begin
            in_valid = (m < 12) ? pat[m] : 1'b0;
            in_a     = rnd16();
            in_b     = rnd16();
            in_cin   = 1'($urandom);
            in_sub   = 1'($urandom);
            @(negedge clk);
            chk("bubble_valid", 32'(out_valid), 32'((m >= 5) ? pat[m-5] : 1'b0));
            @(posedge clk);
            #1;
        end
        idle(6);
        chk("bubble_drained", 32'(sb.size()), 32'd0);

        // Reset mid-flight: outstanding beats must vanish, including one at the output
        for (int i = 0; i < 5; i++) send(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 32'(out_valid), 32'd0);
        chk("midreset_sum", 32'(out_sum), 32'd0);
        sb.delete();
        #9;
        rst_n = 1'b1;
        idle(8);
        fix_en  = 1'b1;
        fix_exp = '{16'h1000, 1'b0, 1'b0};
        latency("latency_after_reset", 16'h00FF, 16'h0F01, 1'b0, 1'b0);
        fix_en = 1'b0;
        idle(6);
        chk("reset_drained", 32'(sb.size()), 32'd0);

        // Randomised traffic with random backpressure
        hold = 1'b0;
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    if (!hold) begin
                        in_valid = ($urandom_range(0, 3) != 0);
                        in_a     = rnd16();
                        in_b     = rnd16();
                        in_cin   = 1'($urandom);
                        in_sub   = 1'($urandom);
                    end
                    @(negedge clk);
                    hold = in_valid && !in_ready;
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int n = 0; n < 400; n++) begin
                    out_ready = ($urandom_range(0, 4) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        idle(12);
        chk("random_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
